// File: rtl/snake_dir_queue_if.sv
// snake_dir_queue_if
//   Groups the control, button-pulse and heading signals of snake_dir_queue.
//   master: game/test side driving requests and ticks, observing the heading.
//   slave : the direction queue itself.
//   Signals:
//     clear      synchronous restart
//     btn_*      one-cycle debounced press pulses (up/right/down/left)
//     move_tick  one-cycle game move pulse
//     dir        registered heading (00 up, 01 right, 10 down, 11 left)
//     turn       one-cycle pulse, dir was loaded from the queue
//     drop       one-cycle pulse, valid request lost because the queue was full
//     pending    number of queued turns
//     reject_cnt saturating reject/drop counter (only with DIR_QUEUE_STATS_EN)
interface snake_dir_queue_if #(
  parameter int QDEPTH = 2
);
  localparam int CW = $clog2(QDEPTH + 1);

  logic          clear;
  logic          btn_up;
  logic          btn_right;
  logic          btn_down;
  logic          btn_left;
  logic          move_tick;
  logic [1:0]    dir;
  logic          turn;
  logic          drop;
  logic [CW-1:0] pending;
`ifdef DIR_QUEUE_STATS_EN
  logic [7:0]    reject_cnt;

  modport master (
    output clear, btn_up, btn_right, btn_down, btn_left, move_tick,
    input  dir, turn, drop, pending, reject_cnt
  );

  modport slave (
    input  clear, btn_up, btn_right, btn_down, btn_left, move_tick,
    output dir, turn, drop, pending, reject_cnt
  );
`else
  modport master (
    output clear, btn_up, btn_right, btn_down, btn_left, move_tick,
    input  dir, turn, drop, pending
  );

  modport slave (
    input  clear, btn_up, btn_right, btn_down, btn_left, move_tick,
    output dir, turn, drop, pending
  );
`endif

endinterface

// File: rtl/snake_dir_queue.sv
// snake_dir_queue
//   Turns debounced direction-button pulses into the snake heading. Valid
//   turns wait in a small circular FIFO and are applied one per move_tick.
//   Requests that repeat or reverse the most recent heading (queued tail, or
//   dir when the queue is empty) are discarded silently; valid requests that
//   find the queue full raise drop.
//   Ports:
//     Clock    system clock, posedge
//     Reset_n  asynchronous active-low reset
//     bus      snake_dir_queue_if.slave (clear, buttons, tick, dir, turn,
//              drop, pending[, reject_cnt])
//   Parameters:
//     QDEPTH   pending-turn capacity, 1..8
//     INIT_DIR heading after reset/clear
//   Build option:
//     DIR_QUEUE_STATS_EN  adds bus.reject_cnt, a saturating count of silent
//                         rejects and drops
module snake_dir_queue #(
  parameter int         QDEPTH   = 2,
  parameter logic [1:0] INIT_DIR = 2'b01
) (
  input logic              Clock,
  input logic              Reset_n,
  snake_dir_queue_if.slave bus
);

  localparam int CW = $clog2(QDEPTH + 1);
  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(QDEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(QDEPTH - 1);

  logic [1:0]    mem [QDEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] tail_ptr;
  logic [CW-1:0] count;
  logic [1:0]    dir_q;
  logic          turn_q;
  logic          drop_q;

  logic          req_valid;
  logic [1:0]    req_dir;
  logic [1:0]    ref_dir;
  logic          req_noop;
  logic          req_accept;
  logic          do_pop;
  logic          do_push;
  logic          do_drop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    // Explicit wrap so non-power-of-two depths work.
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // Fixed priority up > right > down > left; losers vanish without a drop.
  always_comb begin
    req_valid = 1'b1;
    req_dir   = 2'b00;
    if (bus.btn_up)         req_dir = 2'b00;
    else if (bus.btn_right) req_dir = 2'b01;
    else if (bus.btn_down)  req_dir = 2'b10;
    else if (bus.btn_left)  req_dir = 2'b11;
    else                    req_valid = 1'b0;
  end

  // Compare against the heading the snake will have once everything already
  // queued is applied, so a burst of taps is judged turn by turn.
  always_comb begin
    tail_ptr   = (wr_ptr == '0) ? LAST_PTR : wr_ptr - 1'b1;
    ref_dir    = (count != '0) ? mem[tail_ptr] : dir_q;
    req_noop   = req_valid && ((req_dir == ref_dir) || (req_dir == (ref_dir ^ 2'b10)));
    req_accept = req_valid && !req_noop;
    do_pop     = bus.move_tick && (count != '0);
    // A full queue still takes a push when the head leaves in the same cycle.
    do_push    = req_accept && ((count < DEPTH_C) || do_pop);
    do_drop    = req_accept && !do_push;
  end

  // Storage is only read behind a non-zero count, so it needs no reset.
  always_ff @(posedge Clock) begin
    if (do_push && !bus.clear) mem[wr_ptr] <= req_dir;
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      dir_q  <= INIT_DIR;
      turn_q <= 1'b0;
      drop_q <= 1'b0;
    end else if (bus.clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      dir_q  <= INIT_DIR;
      turn_q <= 1'b0;
      drop_q <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop) begin
        dir_q  <= mem[rd_ptr];
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      turn_q <= do_pop;
      drop_q <= do_drop;
    end
  end

  assign bus.dir     = dir_q;
  assign bus.turn    = turn_q;
  assign bus.drop    = drop_q;
  assign bus.pending = count;

`ifdef DIR_QUEUE_STATS_EN
  logic [7:0] rej_cnt;

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      rej_cnt <= '0;
    end else if (bus.clear) begin
      rej_cnt <= '0;
    end else if ((req_noop || do_drop) && (rej_cnt != 8'hFF)) begin
      rej_cnt <= rej_cnt + 1'b1;
    end
  end

  assign bus.reject_cnt = rej_cnt;
`endif

endmodule
